// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin owner arbiter for an 8-way shared mux, grant held per transaction; ARB_TIMEOUT_EN adds a MAX_HOLD revoke
module rr_mux_arbiter #(
  parameter int N_REQ = 8,
  parameter int SEL_W = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             timeout
);
  if (N_REQ != 8 || SEL_W != 3 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_cfg
    $error("rr_mux_arbiter: N_REQ must be 8, SEL_W 3, MAX_HOLD 1..255");
  end
  typedef enum logic {IDLE, OWN} state_t;
  state_t state, state_nx;
  logic [SEL_W-1:0] last, last_nx, sel_nx, ptr, win, idx;
  logic [N_REQ-1:0] grant_nx, cand;
  logic found, done, tmo;
  assign busy = state == OWN;
  assign ptr = state == OWN ? sel : last;
  assign cand = state == OWN ? req & ~grant : req;
  assign found = |cand;
  assign done = state == OWN && (rel || !req[sel] || tmo);
  always_comb begin
    win = ptr;
    idx = ptr;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = ptr + SEL_W'(i);
      win = cand[idx] ? idx : win;
    end
  end
  always_comb begin
    state_nx = state;
    last_nx = last;
    sel_nx = sel;
    grant_nx = grant;
    if (state == IDLE && found) begin
      state_nx = OWN;
      sel_nx = win;
      grant_nx = N_REQ'(1) << win;
    end else if (done) begin
      last_nx = sel;
      sel_nx = found ? win : sel;
      grant_nx = found ? N_REQ'(1) << win : req[sel] ? grant : '0;
      state_nx = found || req[sel] ? OWN : IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      last <= SEL_W'(N_REQ - 1);
      sel <= '0;
      grant <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_nx;
      last <= last_nx;
      sel <= sel_nx;
      grant <= grant_nx;
      timeout <= tmo;
    end
`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt;
  assign tmo = state == OWN && cnt == 8'(MAX_HOLD - 1) && !rel && req[sel];
  // Every new grant, including a re-grant to the same owner, restarts the hold window
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (state == IDLE && found) || done ? '0 : state == OWN ? cnt + 8'd1 : cnt;
`else
  assign tmo = 1'b0;
`endif
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: scoreboard bench for rr_mux_arbiter against a queue-free round-robin reference model
module tb_rr_mux_arbiter;
  localparam int MAX_HOLD = 16;
  typedef struct packed {
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;
  } obs_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rel = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic [2:0] sel;
  logic busy, timeout;
  int tests = 0;
  int fails = 0;
  obs_t q[$];
  obs_t mon_e;
  int owner = -1;
  int last = 7;
  int msel = 0;
  int hold = 0;
  bit mto = 1'b0;
  rr_mux_arbiter #(.N_REQ(8), .SEL_W(3), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
    .grant(grant), .sel(sel), .busy(busy), .timeout(timeout)
  );
  always #5 clk = ~clk;
  function automatic int scan(input logic [7:0] r, input int p);
    for (int k = 1; k <= 8; k++) if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction
  function automatic void model_reset();
    owner = -1;
    last = 7;
    msel = 0;
    hold = 0;
    mto = 1'b0;
  endfunction
  function automatic void model_step(input logic [7:0] r, input logic rl);
    mto = 1'b0;
    if (owner < 0) begin
      if (r != 8'h00) begin
        owner = scan(r, last);
        msel = owner;
        hold = 0;
      end
    end else begin
      bit expire;
      int w;
      expire = 1'b0;
`ifdef ARB_TIMEOUT_EN
      expire = !rl && r[owner] && hold == MAX_HOLD - 1;
`endif
      if (rl || !r[owner] || expire) begin
        w = scan(r & ~(8'd1 << owner), owner);
        last = owner;
        mto = expire;
        hold = 0;
        if (w >= 0) begin
          owner = w;
          msel = w;
        end else if (!r[owner]) owner = -1;
      end else hold++;
    end
  endfunction
  function automatic obs_t expected();
    return {owner < 0 ? 8'h00 : 8'd1 << owner, 3'(msel), owner >= 0, mto};
  endfunction
  function automatic obs_t cur();
    return {grant, sel, busy, timeout};
  endfunction
  task automatic chk(input string n, input obs_t a, input obs_t e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s @%0t: got grant=%b sel=%0d busy=%b timeout=%b, want grant=%b sel=%0d busy=%b timeout=%b",
               n, $time, a.grant, a.sel, a.busy, a.timeout, e.grant, e.sel, e.busy, e.timeout);
    end
  endtask
  task automatic drive(input logic [7:0] r, input logic rl);
    req = r;
    rel = rl;
    if (rst_n) model_step(r, rl);
    q.push_back(expected());
    @(posedge clk);
    #2;
  endtask
  always begin
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      chk("scoreboard", cur(), mon_e);
    end
    tests++;
    if ($countones(grant) > 1) begin
      fails++;
      $display("FAIL onehot @%0t: got grant=%b, want at most one bit set", $time, grant);
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t want under 2000000", $time);
    $fatal(1);
  end
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_values", cur(), {8'h00, 3'd0, 1'b0, 1'b0});
    rst_n = 1'b1;
    drive(8'h05, 1'b0);
    chk("first_grant", cur(), {8'h01, 3'd0, 1'b1, 1'b0});
    drive(8'h05, 1'b1);
    chk("release_to_2", cur(), {8'h04, 3'd2, 1'b1, 1'b0});
    drive(8'h05, 1'b0);
    drive(8'h05, 1'b1);
    chk("wrap_to_0", cur(), {8'h01, 3'd0, 1'b1, 1'b0});
    for (int i = 0; i < 8; i++) begin
      drive(8'hFF, 1'b0);
      drive(8'hFF, 1'b0);
      drive(8'hFF, 1'b1);
      chk("rotate_all", cur(), {8'd1 << ((i + 1) % 8), 3'((i + 1) % 8), 1'b1, 1'b0});
    end
    drive(8'h20, 1'b0);
    chk("single_5", cur(), {8'h20, 3'd5, 1'b1, 1'b0});
    drive(8'h20, 1'b1);
    chk("regrant_5", cur(), {8'h20, 3'd5, 1'b1, 1'b0});
    drive(8'h00, 1'b0);
    chk("withdraw_5", cur(), {8'h00, 3'd5, 1'b0, 1'b0});
    drive(8'h08, 1'b0);
    chk("grant_3", cur(), {8'h08, 3'd3, 1'b1, 1'b0});
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", cur(), {8'h00, 3'd0, 1'b0, 1'b0});
    q.delete();
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(8'h88, 1'b0);
    chk("post_reset_3", cur(), {8'h08, 3'd3, 1'b1, 1'b0});
    drive(8'h03, 1'b0);
    chk("hold_start_0", cur(), {8'h01, 3'd0, 1'b1, 1'b0});
    for (int i = 0; i < 16; i++) drive(8'h03, 1'b0);
`ifdef ARB_TIMEOUT_EN
    chk("timeout_move", cur(), {8'h02, 3'd1, 1'b1, 1'b1});
`else
    chk("no_timeout_16", cur(), {8'h01, 3'd0, 1'b1, 1'b0});
    for (int i = 0; i < 100; i++) drive(8'h03, 1'b0);
    chk("no_timeout_116", cur(), {8'h01, 3'd0, 1'b1, 1'b0});
`endif
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      r = $urandom_range(0, 3) == 0 ? 8'($urandom) : req;
      drive(r, $urandom_range(0, 3) == 0);
    end
    drive(8'h00, 1'b0);
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
